multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 174 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB (+TRAP) control FSM with a retired-instruction counter.
// Build option: define ILLEGAL_TRAP_EN to park in TRAP on an illegal opcode instead of skipping it.
module multicycle_sequencer #(
  parameter logic [15:0] COUNT_RESET = 16'h0000  // reset value of the retired-instruction counter
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic        illegal_op,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    TRAP   = 3'b101
  } state_t;

  localparam logic [3:0] OP_JUMP   = 4'b0000;
  localparam logic [3:0] OP_RTYPE  = 4'b0001;
  localparam logic [3:0] OP_LW     = 4'b0010;
  localparam logic [3:0] OP_SW     = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0100;

  state_t      state_reg, state_next;
  logic [3:0]  op_reg;
  logic [15:0] count_reg;
  logic        retire;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= FETCH;
      op_reg    <= 4'b0000;
      count_reg <= COUNT_RESET;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) op_reg <= opcode;
      if (retire) count_reg <= count_reg + 16'd1;
    end
  end

  always_comb begin
    state_next   = FETCH;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    pc_src       = 2'b00;
    illegal_op   = 1'b0;

    case (state_reg)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      // Decode looks at the live opcode; op_reg only holds it from EXEC onward.
      DECODE: begin
        if (opcode <= OP_BRANCH) begin
          state_next = EXEC;
        end else begin
          illegal_op = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_next = TRAP;
`else
          state_next = FETCH;
`endif
        end
      end
      EXEC: begin
        case (op_reg)
          OP_RTYPE: begin
            alu_op     = 2'b10;
            state_next = WB;
          end
          OP_LW, OP_SW: begin
            alu_src    = 1'b1;
            state_next = MEM;
          end
          OP_BRANCH: begin
            alu_op   = 2'b01;
            pc_src   = 2'b01;
            pc_write = zero;
            retire   = 1'b1;
          end
          OP_JUMP: begin
            alu_op   = 2'b11;
            pc_src   = 2'b10;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          default: state_next = FETCH;
        endcase
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        alu_src      = 1'b1;
        mem_write    = (op_reg == OP_SW);
        if (!mem_ready) begin
          state_next = MEM;
        end else if (op_reg == OP_SW) begin
          retire = 1'b1;
        end else begin
          state_next = WB;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_reg == OP_RTYPE);
        mem_to_reg = (op_reg != OP_RTYPE);
        retire     = 1'b1;
      end
      TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
        state_next = TRAP;
`else
        state_next = FETCH;
`endif
      end
      default: state_next = FETCH;
    endcase

    // Reset overrides every control output, even mid-transaction.
    if (!reset_n) begin
      mem_req      = 1'b0;
      mem_write    = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src      = 1'b0;
      alu_op       = 2'b00;
      pc_src       = 2'b00;
      illegal_op   = 1'b0;
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer; inputs change and outputs are sampled just after each falling edge.
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_write, mem_addr_sel, ir_write, pc_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src, illegal_op;
  logic [1:0]  alu_op, pc_src;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic        w2_mem_req, w2_mem_write, w2_mem_addr_sel, w2_ir_write, w2_pc_write, w2_reg_write;
  logic        w2_reg_dst, w2_mem_to_reg, w2_alu_src, w2_illegal_op;
  logic [1:0]  w2_alu_op, w2_pc_src;
  logic [2:0]  w2_state;
  logic [15:0] w2_instr_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count = 16'd0;

  localparam logic [13:0] MREQ    = 14'h2000;
  localparam logic [13:0] MWR     = 14'h1000;
  localparam logic [13:0] ASEL    = 14'h0800;
  localparam logic [13:0] IRW     = 14'h0400;
  localparam logic [13:0] PCW     = 14'h0200;
  localparam logic [13:0] RGW     = 14'h0100;
  localparam logic [13:0] RDST    = 14'h0080;
  localparam logic [13:0] M2R     = 14'h0040;
  localparam logic [13:0] ASRC    = 14'h0020;
  localparam logic [13:0] AOP_FN  = 14'h0010;
  localparam logic [13:0] AOP_SUB = 14'h0008;
  localparam logic [13:0] AOP_11  = 14'h0018;
  localparam logic [13:0] PC_J    = 14'h0004;
  localparam logic [13:0] PC_BR   = 14'h0002;
  localparam logic [13:0] ILL     = 14'h0001;
  localparam logic [13:0] FETCHGO = MREQ | IRW | PCW;

  wire [13:0] ctl  = {mem_req, mem_write, mem_addr_sel, ir_write, pc_write, reg_write,
                      reg_dst, mem_to_reg, alu_src, alu_op, pc_src, illegal_op};
  wire [13:0] ctl2 = {w2_mem_req, w2_mem_write, w2_mem_addr_sel, w2_ir_write, w2_pc_write, w2_reg_write,
                      w2_reg_dst, w2_mem_to_reg, w2_alu_src, w2_alu_op, w2_pc_src, w2_illegal_op};

  multicycle_sequencer dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .pc_src(pc_src), .state(state),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  // Second instance starts its counter one short of wrapping.
  multicycle_sequencer #(.COUNT_RESET(16'hFFFF)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(w2_mem_req), .mem_write(w2_mem_write), .mem_addr_sel(w2_mem_addr_sel), .ir_write(w2_ir_write),
    .pc_write(w2_pc_write), .reg_write(w2_reg_write), .reg_dst(w2_reg_dst), .mem_to_reg(w2_mem_to_reg),
    .alu_src(w2_alu_src), .alu_op(w2_alu_op), .pc_src(w2_pc_src), .state(w2_state),
    .illegal_op(w2_illegal_op), .instr_count(w2_instr_count)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset_n = 1'b0; opcode = 4'd1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      checks++; if (ctl !== 14'h0) begin errors++; $display("FAIL reset ctl: got %h want %h", ctl, 14'h0); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset state: got %0d want 0", state); end
    end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset count: got %h want 0000", instr_count); end
    checks++; if (w2_instr_count !== 16'hFFFF) begin errors++; $display("FAIL reset preload count: got %h want ffff", w2_instr_count); end
    $display("reset: ctl=%h state=%0d count=%h", ctl, state, instr_count);
    reset_n = 1'b1;
    exp_count = 16'd0;
  endtask

  task automatic test_rtype();
    logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [13:0] ec [4] = '{FETCHGO, 14'h0, AOP_FN, RGW | RDST};
    opcode = 4'd1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL rtype state c%0d: got %0d want %0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL rtype ctl c%0d: got %h want %h", i, ctl, ec[i]); end
      @(negedge clock);
    end
    #1; exp_count++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rtype end state: got %0d want 0", state); end
    checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL rtype count: got %h want %h", instr_count, exp_count); end
    $display("rtype: count=%h", instr_count);
  endtask

  task automatic test_lw_wait();
    logic        rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  op [7] = '{4'd2, 4'd2, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [2:0]  es [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    logic [13:0] ec [7] = '{FETCHGO, 14'h0, ASRC, MREQ | ASEL | ASRC, MREQ | ASEL | ASRC,
                            MREQ | ASEL | ASRC, RGW | M2R};
    for (int i = 0; i < 7; i++) begin
      mem_ready = rd[i]; opcode = op[i]; #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL lw state c%0d: got %0d want %0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL lw ctl c%0d: got %h want %h", i, ctl, ec[i]); end
      @(negedge clock);
    end
    mem_ready = 1'b1; #1; exp_count++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL lw end state: got %0d want 0", state); end
    checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL lw count: got %h want %h", instr_count, exp_count); end
    $display("lw with 2 wait cycles: count=%h", instr_count);
  endtask

  task automatic test_sw();
    logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [13:0] ec [4] = '{FETCHGO, 14'h0, ASRC, MREQ | MWR | ASEL | ASRC};
    opcode = 4'd3; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL sw state c%0d: got %0d want %0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL sw ctl c%0d: got %h want %h", i, ctl, ec[i]); end
      @(negedge clock);
    end
    #1; exp_count++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL sw end state: got %0d want 0", state); end
    checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL sw count: got %h want %h", instr_count, exp_count); end
    $display("sw: count=%h", instr_count);
  endtask

  task automatic test_branch(input logic z);
    logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd2};
    logic [13:0] ec [3];
    ec[0] = FETCHGO; ec[1] = 14'h0; ec[2] = AOP_SUB | PC_BR | (z ? PCW : 14'h0);
    opcode = 4'd4; mem_ready = 1'b1; zero = z;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL branch z=%0b state c%0d: got %0d want %0d", z, i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL branch z=%0b ctl c%0d: got %h want %h", z, i, ctl, ec[i]); end
      @(negedge clock);
    end
    zero = 1'b0; #1; exp_count++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL branch end state: got %0d want 0", state); end
    checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL branch count: got %h want %h", instr_count, exp_count); end
    $display("branch zero=%0b: count=%h", z, instr_count);
  endtask

  task automatic test_jump();
    logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd2};
    logic [13:0] ec [3] = '{FETCHGO, 14'h0, PC_J | PCW | AOP_11};
    opcode = 4'd0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL jump state c%0d: got %0d want %0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL jump ctl c%0d: got %h want %h", i, ctl, ec[i]); end
      @(negedge clock);
    end
    #1; exp_count++;
    checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL jump count: got %h want %h", instr_count, exp_count); end
    $display("jump: count=%h", instr_count);
  endtask

  task automatic test_illegal();
    opcode = 4'd7; mem_ready = 1'b1; #1;
    checks++; if (ctl !== FETCHGO) begin errors++; $display("FAIL illegal fetch ctl: got %h want %h", ctl, FETCHGO); end
    @(negedge clock); #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL illegal decode state: got %0d want 1", state); end
    checks++; if (ctl !== ILL) begin errors++; $display("FAIL illegal decode ctl: got %h want %h", ctl, ILL); end
`ifdef ILLEGAL_TRAP_EN
    opcode = 4'd1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock); #1;
      checks++; if (state !== 3'd5) begin errors++; $display("FAIL trap state c%0d: got %0d want 5", i, state); end
      checks++; if (ctl !== ILL) begin errors++; $display("FAIL trap ctl c%0d: got %h want %h", i, ctl, ILL); end
      checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL trap count c%0d: got %h want %h", i, instr_count, exp_count); end
    end
    $display("illegal (trap): state=%0d illegal_op=%0b", state, illegal_op);
`else
    @(negedge clock); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL illegal return state: got %0d want 0", state); end
    checks++; if (ctl !== FETCHGO) begin errors++; $display("FAIL illegal return ctl: got %h want %h", ctl, FETCHGO); end
    checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL illegal count: got %h want %h", instr_count, exp_count); end
    $display("illegal (nop): state=%0d illegal_op=%0b", state, illegal_op);
`endif
  endtask

  task automatic test_reset_mid_sw();
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
    reset_n = 1'b0; #1;
    checks++; if (ctl !== 14'h0) begin errors++; $display("FAIL midrst pre ctl: got %h want 0", ctl); end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1; exp_count = 16'd0; opcode = 4'd3;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i]; #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL midrst sw state c%0d: got %0d want %0d", i, state, es[i]); end
      if (i < 4) @(negedge clock);
    end
    checks++; if (ctl !== (MREQ | MWR | ASEL | ASRC)) begin errors++; $display("FAIL midrst mem ctl: got %h want %h", ctl, MREQ | MWR | ASEL | ASRC); end
    reset_n = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst mem_req: got %0b want 0", mem_req); end
    @(negedge clock); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL midrst state: got %0d want 0", state); end
    checks++; if (ctl !== 14'h0) begin errors++; $display("FAIL midrst ctl: got %h want 0", ctl); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL midrst count: got %h want 0000", instr_count); end
    reset_n = 1'b1; mem_ready = 1'b1; #1;
    checks++; if (ctl !== FETCHGO) begin errors++; $display("FAIL midrst release ctl: got %h want %h", ctl, FETCHGO); end
    $display("reset during sw MEM: state=%0d count=%h", state, instr_count);
  endtask

  task automatic test_wrap();
    checks++; if (w2_instr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap start: got %h want ffff", w2_instr_count); end
    test_jump();
    checks++; if (w2_instr_count !== 16'h0000) begin errors++; $display("FAIL wrap count: got %h want 0000", w2_instr_count); end
    checks++; if (w2_state !== 3'd0) begin errors++; $display("FAIL wrap state: got %0d want 0", w2_state); end
    checks++; if (ctl2 !== FETCHGO) begin errors++; $display("FAIL wrap ctl: got %h want %h", ctl2, FETCHGO); end
    $display("wrap: count=%h", w2_instr_count);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_illegal();
    test_reset_mid_sw();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
